// File: rtl/letter_tx_queue_if.sv
// Producer, transmitter and status signals of the letter transmit queue.
// The queue itself attaches through the slave modport.
interface letter_tx_queue_if #(
    parameter int DATA_WIDTH = 5,
    parameter int DEPTH      = 1000
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic                  data_valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  flush_in;
    logic                  tx_busy_in;
    logic                  tx_valid_out;
    logic [DATA_WIDTH-1:0] tx_data_out;
    logic [CW-1:0]         count_out;
    logic                  empty_out;
    logic                  full_out;
    logic                  overflow_out;
    logic                  timeout_out;

    modport master (
        output data_valid_in, data_in, flush_in, tx_busy_in,
        input  tx_valid_out, tx_data_out, count_out,
        input  empty_out, full_out, overflow_out, timeout_out
    );

    modport slave (
        input  data_valid_in, data_in, flush_in, tx_busy_in,
        output tx_valid_out, tx_data_out, count_out,
        output empty_out, full_out, overflow_out, timeout_out
    );
endinterface

// File: rtl/letter_tx_queue.sv
// Transmit FIFO feeding a busy-signalling IR transmitter one letter at a time.
// Any depth, drop-new or drop-oldest overflow, flush, and a busy timeout.
module letter_tx_queue #(
    parameter int DATA_WIDTH   = 5,
    parameter int DEPTH        = 1000,
    parameter int READ_LATENCY = 2,
    parameter bit DROP_OLDEST  = 1'b0,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic             clk_in,
    input  logic             rst_in,
    letter_tx_queue_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, full_q;
    logic                  ovf_q, ovf_d;
    logic                  to_q, to_d;
    logic [2:0]            state_q, state_d;
    logic [1:0]            lat_q, lat_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_WIDTH-1:0] m1_q, m2_q;
    logic [DATA_WIDTH-1:0] txd_q, txd_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  pop, wr_store, wr_adv_rd;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop     = (state_q == S_IDLE) && !empty_q && !bus.tx_busy_in;
    assign rd_data = (READ_LATENCY == 1) ? m1_q : m2_q;

    // Pointer, occupancy and overflow next-state; flush wins over a write.
    always_comb begin
        wr_store  = 1'b0;
        wr_adv_rd = 1'b0;
        ovf_d     = ovf_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (bus.flush_in) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (bus.data_valid_in) begin
                if (!full_q || pop) begin
                    wr_store = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                    if (DROP_OLDEST) begin
                        wr_store  = 1'b1;
                        wr_adv_rd = 1'b1;
                    end
                end
            end
            if (wr_store)
                wr_ptr_d = inc(wr_ptr_q);
            if (pop || wr_adv_rd)
                rd_ptr_d = inc(rd_ptr_q);
            if (wr_store && !pop && !wr_adv_rd)
                count_d = count_q + 1'b1;
            else if (pop && !wr_store)
                count_d = count_q - 1'b1;
        end
    end

    // Scheduler: pop, wait out memory latency, strobe, then track busy.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        timer_d = timer_q;
        txd_d   = txd_q;
        to_d    = to_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    lat_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (lat_q == 2'(READ_LATENCY - 1)) begin
                    txd_d   = rd_data;
                    state_d = S_ISSUE;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.tx_busy_in) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy_in)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Storage and read pipeline; the read address is the pointer at pop time.
    always_ff @(posedge clk_in) begin
        if (wr_store)
            mem_q[wr_ptr_q] <= bus.data_in;
        m1_q <= mem_q[rd_ptr_q];
        m2_q <= m1_q;
    end

    // Control and status registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
            state_q  <= S_IDLE;
            lat_q    <= '0;
            timer_q  <= '0;
            txd_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == CW'(DEPTH));
            ovf_q    <= ovf_d;
            to_q     <= to_d;
            state_q  <= state_d;
            lat_q    <= lat_d;
            timer_q  <= timer_d;
            txd_q    <= txd_d;
        end
    end

    assign bus.tx_valid_out = (state_q == S_ISSUE);
    assign bus.tx_data_out  = txd_q;
    assign bus.count_out    = count_q;
    assign bus.empty_out    = empty_q;
    assign bus.full_out     = full_q;
    assign bus.overflow_out = ovf_q;
    assign bus.timeout_out  = to_q;
endmodule

// File: tb/tb_letter_tx_queue.sv
// Directed bench for letter_tx_queue: three instances share the write side,
// each with its own transmitter model (busy 20 cycles, starting 2 after a strobe).
module tb_letter_tx_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, vld, fl, hold, nobusy;
    logic [4:0] dat;
    int         checks = 0;
    int         errors = 0;
    int         since [3];
    int         maxc1;
    logic [2:0] txv;
    logic [4:0] sq0 [$];
    logic [4:0] sq1 [$];
    logic [4:0] sq2 [$];

    letter_tx_queue_if #(.DATA_WIDTH(5), .DEPTH(4)) i0 ();
    letter_tx_queue_if #(.DATA_WIDTH(5), .DEPTH(4)) i1 ();
    letter_tx_queue_if #(.DATA_WIDTH(5), .DEPTH(5)) i2 ();

    letter_tx_queue #(
        .DATA_WIDTH(5), .DEPTH(4), .READ_LATENCY(2),
        .DROP_OLDEST(1'b0), .BUSY_TIMEOUT(16)
    ) u0 (.clk_in(clk), .rst_in(rst), .bus(i0));

    letter_tx_queue #(
        .DATA_WIDTH(5), .DEPTH(4), .READ_LATENCY(2),
        .DROP_OLDEST(1'b1), .BUSY_TIMEOUT(16)
    ) u1 (.clk_in(clk), .rst_in(rst), .bus(i1));

    letter_tx_queue #(
        .DATA_WIDTH(5), .DEPTH(5), .READ_LATENCY(1),
        .DROP_OLDEST(1'b0), .BUSY_TIMEOUT(16)
    ) u2 (.clk_in(clk), .rst_in(rst), .bus(i2));

    assign i0.data_valid_in = vld;
    assign i1.data_valid_in = vld;
    assign i2.data_valid_in = vld;
    assign i0.data_in = dat;
    assign i1.data_in = dat;
    assign i2.data_in = dat;
    assign i0.flush_in = fl;
    assign i1.flush_in = fl;
    assign i2.flush_in = fl;
    assign i0.tx_busy_in = hold | (!nobusy && since[0] >= 2 && since[0] < 22);
    assign i1.tx_busy_in = hold | (!nobusy && since[1] >= 2 && since[1] < 22);
    assign i2.tx_busy_in = hold | (!nobusy && since[2] >= 2 && since[2] < 22);
    assign txv = {i2.tx_valid_out, i1.tx_valid_out, i0.tx_valid_out};

    // Transmitter model: cycles elapsed since the last strobe.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst)
                since[k] <= 0;
            else if (txv[k])
                since[k] <= 1;
            else if (since[k] != 0 && since[k] < 22)
                since[k] <= since[k] + 1;
            else
                since[k] <= 0;
        end
    end

    // Strobe capture and peak occupancy of the drop-oldest instance.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (i0.tx_valid_out) sq0.push_back(i0.tx_data_out);
            if (i1.tx_valid_out) sq1.push_back(i1.tx_data_out);
            if (i2.tx_valid_out) sq2.push_back(i2.tx_data_out);
            if (int'(i1.count_out) > maxc1) maxc1 = int'(i1.count_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input logic [4:0] q [$],
                           input int first, input int step, input int n);
        chk({tag, " n"}, q.size(), n);
        for (int i = 0; i < n; i++)
            if (i < q.size())
                chk($sformatf("%s[%0d]", tag, i), 32'(q[i]), first + step * i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = 1'b0;
        fl  = 1'b0;
        ticks(2);
        rst = 1'b0;
        sq0.delete();
        sq1.delete();
        sq2.delete();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " count"}, i0.count_out, 0);
        chk({tag, " empty"}, i0.empty_out, 1);
        chk({tag, " full"}, i0.full_out, 0);
        chk({tag, " valid"}, i0.tx_valid_out, 0);
        chk({tag, " data"}, i0.tx_data_out, 0);
        chk({tag, " ovf"}, i0.overflow_out, 0);
        chk({tag, " tmo"}, i0.timeout_out, 0);
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; fl = 1'b0; dat = '0;
        hold = 1'b0; nobusy = 1'b0; maxc1 = 0;
        ticks(2);
        rst = 1'b0;
        chk_reset_state("rst");

        // In-order delivery and pop-to-strobe latency for RL=2 and RL=1.
        do_reset();
        hold = 1'b1;
        vld = 1'b1; dat = 5'd3;
        tick(); dat = 5'd7;
        tick(); dat = 5'd11;
        tick(); vld = 1'b0;
        chk("basic count3", i0.count_out, 3);
        hold = 1'b0;
        tick();
        chk("basic count2", i0.count_out, 2);
        tick();
        chk("rl2 early", i0.tx_valid_out, 0);
        chk("rl1 strobe", i2.tx_valid_out, 1);
        chk("rl1 data", i2.tx_data_out, 3);
        tick();
        chk("rl2 strobe", i0.tx_valid_out, 1);
        chk("rl2 data", i0.tx_data_out, 3);
        ticks(110);
        chk_seq("basic u0", sq0, 3, 4, 3);
        chk_seq("basic u2", sq2, 3, 4, 3);
        chk("basic end count", i0.count_out, 0);
        chk("basic end empty", i0.empty_out, 1);

        // Overflow with the transmitter held busy: drop-new vs drop-oldest.
        do_reset();
        maxc1 = 0;
        hold = 1'b1;
        vld = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            dat = 5'(i);
            tick();
        end
        vld = 1'b0;
        chk("ovf0 count", i0.count_out, 4);
        chk("ovf0 full", i0.full_out, 1);
        chk("ovf0 flag", i0.overflow_out, 1);
        chk("ovf1 count", i1.count_out, 4);
        chk("ovf1 full", i1.full_out, 1);
        chk("ovf1 flag", i1.overflow_out, 1);
        chk("ovf d5 count", i2.count_out, 5);
        hold = 1'b0;
        ticks(140);
        chk_seq("drop new", sq0, 1, 1, 4);
        chk_seq("drop old", sq1, 3, 1, 4);
        chk_seq("drop d5", sq2, 1, 1, 5);
        chk("drop old max", maxc1, 4);
        chk("drop new empty", i0.empty_out, 1);

        // DEPTH=5: 12 writes in bursts, write pointer wraps twice.
        do_reset();
        for (int b = 0; b < 4; b++) begin
            vld = 1'b1;
            for (int j = 0; j < 3; j++) begin
                dat = 5'(10 + 3 * b + j);
                tick();
            end
            vld = 1'b0;
            ticks(80);
        end
        ticks(20);
        chk_seq("wrap d5", sq2, 10, 1, 12);
        chk("wrap ovf", i2.overflow_out, 0);
        chk("wrap empty", i2.empty_out, 1);

        // DEPTH=5: write and pop together while full.
        do_reset();
        hold = 1'b1;
        vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dat = 5'(20 + i);
            tick();
        end
        chk("full d5 count", i2.count_out, 5);
        chk("full d5 flag", i2.full_out, 1);
        dat = 5'd25;
        hold = 1'b0;
        tick();
        vld = 1'b0;
        chk("wrpop count", i2.count_out, 5);
        chk("wrpop full", i2.full_out, 1);
        chk("wrpop ovf", i2.overflow_out, 0);
        ticks(160);
        chk_seq("wrpop seq", sq2, 20, 1, 6);

        // Busy timeout with a transmitter that never answers.
        do_reset();
        nobusy = 1'b1;
        vld = 1'b1; dat = 5'd9;
        tick(); dat = 5'd10;
        tick(); vld = 1'b0;
        ticks(2);
        chk("tmo strobe9", i0.tx_valid_out, 1);
        chk("tmo data9", i0.tx_data_out, 9);
        ticks(16);
        chk("tmo before", i0.timeout_out, 0);
        tick();
        chk("tmo after", i0.timeout_out, 1);
        ticks(3);
        chk("tmo strobe10", i0.tx_valid_out, 1);
        chk("tmo data10", i0.tx_data_out, 10);
        ticks(25);
        chk_seq("tmo seq", sq0, 9, 1, 2);
        nobusy = 1'b0;

        // Flush during WAIT_DONE with a colliding write.
        do_reset();
        hold = 1'b1;
        vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dat = 5'(20 + i);
            tick();
        end
        vld = 1'b0;
        hold = 1'b0;
        tick();
        chk("flush pre count", i0.count_out, 3);
        ticks(10);
        fl = 1'b1; vld = 1'b1; dat = 5'd31;
        tick();
        fl = 1'b0; vld = 1'b0;
        chk("flush count", i0.count_out, 0);
        chk("flush empty", i0.empty_out, 1);
        chk("flush ovf", i0.overflow_out, 0);
        ticks(60);
        chk_seq("flush seq", sq0, 20, 0, 1);

        // Reset during WAIT_DONE with two letters queued.
        do_reset();
        hold = 1'b1;
        vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dat = 5'(30 + i);
            tick();
        end
        vld = 1'b0;
        hold = 1'b0;
        ticks(9);
        chk("midrst pre count", i0.count_out, 2);
        rst = 1'b1;
        tick();
        chk_reset_state("midrst");
        rst = 1'b0;
        sq0.delete();
        ticks(60);
        chk("midrst quiet", sq0.size(), 0);
        vld = 1'b1; dat = 5'd7;
        tick();
        vld = 1'b0;
        ticks(30);
        chk_seq("midrst new", sq0, 7, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
